// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-to-memory bus bridge: FSM states, access
// size codes and the default bus timeout.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 64;
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: write enables/replication and misalign detection for the
// incoming access, and zero-extended lane extraction for returning read data.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  wr_off_i,
  input  logic [1:0]  wr_size_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic        misalign_o,
  input  logic [1:0]  rd_off_i,
  input  logic [1:0]  rd_size_i,
  input  logic [31:0] rdata_raw_i,
  output logic [31:0] rdata_ext_o
);

  always_comb begin
    be_o        = '0;
    wdata_rep_o = '0;
    misalign_o  = 1'b0;
    case (wr_size_i)
      SIZE_BYTE: begin
        be_o        = 4'b0001 << wr_off_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_o        = wr_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        misalign_o  = wr_off_i[0];
      end
      default: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        misalign_o  = |wr_off_i;
      end
    endcase
  end

  always_comb begin
    rdata_ext_o = '0;
    case (rd_size_i)
      SIZE_BYTE: rdata_ext_o = {24'b0, rdata_raw_i[{rd_off_i, 3'b000} +: 8]};
      SIZE_HALF: rdata_ext_o = rd_off_i[1] ? {16'b0, rdata_raw_i[31:16]}
                                           : {16'b0, rdata_raw_i[15:0]};
      default:   rdata_ext_o = rdata_raw_i;
    endcase
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// CPU load/store to single-request memory bus bridge with misalign, timeout
// and read/write-conflict error reporting.
module mem_bus_bridge
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_size,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [29:0]        addr_q;
  logic [31:0]        wdata_q;
  logic               we_q;
  logic [3:0]         be_q;
  logic [1:0]         off_q;
  logic [1:0]         size_q;
  logic               conflict_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               strobe, is_idle, is_busy, timeout_hit, misalign;
  logic [3:0]         be_w;
  logic [31:0]        wdata_w, rdata_ext;

  assign strobe      = cpu_read | cpu_write;
  assign is_idle     = (state_q == ST_IDLE);
  assign is_busy     = (state_q == ST_BUSY);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Write path steers the live CPU request; read path uses the latched access.
  mem_lane_align u_align (
    .wr_off_i    (cpu_addr[1:0]),
    .wr_size_i   (cpu_size),
    .wdata_i     (cpu_wdata),
    .be_o        (be_w),
    .wdata_rep_o (wdata_w),
    .misalign_o  (misalign),
    .rd_off_i    (off_q),
    .rd_size_i   (size_q),
    .rdata_raw_i (bus_rdata),
    .rdata_ext_o (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe) state_d = misalign ? ST_DONE : ST_BUSY;
      ST_BUSY: if (bus_ready || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = is_busy;
    cpu_stall = is_busy | (is_idle & strobe);
  end

  always_comb begin
    cnt_d = '0;
    if (is_busy) cnt_d = bus_ready ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (is_idle && strobe) begin
        addr_q     <= cpu_addr[31:2];
        wdata_q    <= wdata_w;
        we_q       <= cpu_write;
        be_q       <= be_w;
        off_q      <= cpu_addr[1:0];
        size_q     <= cpu_size;
        conflict_q <= cpu_read & cpu_write;
      end
      // Both registers are nonzero only in the cycle following BUSY/IDLE exit.
      rdata_q <= (is_busy && bus_ready && !we_q) ? rdata_ext : '0;
      err_q   <= (is_idle && strobe && misalign)
               | (is_busy && bus_ready && conflict_q)
               | (is_busy && !bus_ready && timeout_hit);
    end
  end

  assign bus_addr  = {addr_q, 2'b00};
  assign bus_wdata = wdata_q;
  assign bus_we    = we_q;
  assign bus_be    = be_q;
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Transaction-level checks of mem_bus_bridge against an arithmetic model of
// lane steering, error rules and cycle counts.
module tb_mem_bus_bridge;

  localparam int unsigned T = 4;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_read, cpu_write, cpu_stall, cpu_err;
  logic [1:0]  cpu_size;
  logic        bus_req, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_bus_bridge #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_size  (cpu_size),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_err   (cpu_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU access; the bus target raises ready after wait_n request cycles.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [1:0] sz, input logic [31:0] wd,
                           input logic [31:0] rbus, input int unsigned wait_n);
    int unsigned nb, off, req_exp, stall_cnt, req_cnt;
    bit mis, to, done;
    logic [31:0] be_exp, wd_exp, rd_exp, mask, b;

    nb   = 1 << ((sz == 2'd3) ? 2 : int'(sz));
    off  = addr % 4;
    mis  = (addr % nb) != 0;
    to   = !mis && (wait_n >= T);
    req_exp = mis ? 0 : (to ? T : wait_n + 1);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    be_exp = ((32'd1 << nb) - 1) << off;
    wd_exp = '0;
    for (int i = 0; i < 4; i++) begin
      b = (wd >> (8 * (i % nb))) & 32'hFF;
      wd_exp = wd_exp | (b << (8 * i));
    end
    rd_exp = (rd && !wr && !mis && !to) ? ((rbus >> (8 * off)) & mask) : '0;

    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_size = sz; cpu_wdata = wd;
    stall_cnt = 0; req_cnt = 0; done = 0;
    for (int c = 0; c < int'(T) + 8 && !done; c++) begin
      #1;
      if (c > 0 && !cpu_stall) begin
        check_eq("done_err", {31'b0, cpu_err}, {31'b0, mis | to | (rd & wr)});
        check_eq("done_req_low", {31'b0, bus_req}, 32'd0);
        if (!(wr && !mis && !to)) check_eq("done_rdata", cpu_rdata, rd_exp);
        check_eq("stall_cycles", stall_cnt, 1 + req_exp);
        check_eq("req_cycles", req_cnt, req_exp);
        cpu_read = 1'b0; cpu_write = 1'b0;
        done = 1;
      end else begin
        if (cpu_stall) stall_cnt++;
        if (bus_req) begin
          check_eq("bus_addr", bus_addr, {addr[31:2], 2'b00});
          check_eq("bus_be", {28'b0, bus_be}, be_exp);
          check_eq("bus_we", {31'b0, bus_we}, {31'b0, wr});
          if (wr) check_eq("bus_wdata", bus_wdata, wd_exp);
          bus_ready = (req_cnt == wait_n);
          bus_rdata = bus_ready ? rbus : $urandom;
          req_cnt++;
        end else begin
          bus_ready = 1'($urandom % 2);
          bus_rdata = $urandom;
        end
        @(negedge clk);
      end
    end
    if (!done) check_eq("done_within_budget", 32'd0, 32'd1);
    bus_ready = 1'b0;
  endtask

  initial begin
    int unsigned mode;
    logic [31:0] a;
    reset = 1'b0; cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    cpu_size = '0; bus_ready = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req", {31'b0, bus_req}, 32'd0);
    check_eq("rst_we", {31'b0, bus_we}, 32'd0);
    check_eq("rst_be", {28'b0, bus_be}, 32'd0);
    check_eq("rst_addr", bus_addr, 32'd0);
    check_eq("rst_wdata", bus_wdata, 32'd0);
    check_eq("rst_rdata", cpu_rdata, 32'd0);
    check_eq("rst_err", {31'b0, cpu_err}, 32'd0);
    check_eq("rst_stall", {31'b0, cpu_stall}, 32'd0);
    reset = 1'b1; bus_ready = 1'b0;

    do_access(1, 0, 32'h100, 2'b10, 32'h0, 32'h1234_5678, 0);
    do_access(0, 1, 32'h203, 2'b00, 32'hAB, 32'h0, 0);
    do_access(1, 0, 32'h102, 2'b01, 32'h0, 32'hBEEF_1234, 3);
    do_access(1, 0, 32'h101, 2'b10, 32'h0, 32'hDEAD_BEEF, 0);
    do_access(1, 0, 32'h400, 2'b10, 32'h0, 32'hCAFE_F00D, 10);
    do_access(1, 1, 32'h500, 2'b11, 32'h1111_2222, 32'h0, 1);
    do_access(0, 1, 32'h601, 2'b01, 32'hAAAA_5555, 32'h0, 0);
    do_access(1, 0, 32'h702, 2'b00, 32'h0, 32'h00C3_0000, 2);

    // Reset while waiting on the bus drops the access silently.
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h300; cpu_size = 2'b10; bus_ready = 1'b0;
    @(negedge clk); #1;
    check_eq("rstbusy_req_before", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    reset = 1'b0; cpu_read = 1'b0;
    @(negedge clk); #1;
    check_eq("rstbusy_req", {31'b0, bus_req}, 32'd0);
    check_eq("rstbusy_err", {31'b0, cpu_err}, 32'd0);
    check_eq("rstbusy_stall", {31'b0, cpu_stall}, 32'd0);
    check_eq("rstbusy_addr", bus_addr, 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("rstbusy_after_err", {31'b0, cpu_err}, 32'd0);
      check_eq("rstbusy_after_req", {31'b0, bus_req}, 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      mode = $urandom % 8;
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      do_access(mode < 4 || mode == 7, mode >= 4, a, 2'($urandom % 4),
                $urandom, $urandom, $urandom % 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 Parameter TIMEOUT, default 64, meaning max BUSY cycles waiting for bus_ready (legal 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 cpu_addr  input  32  byte address from CPU memory-address mux.
REQ-005 cpu_wdata  input  32  store data (right-aligned).
REQ-006 cpu_read  input  1  read strobe; held until cpu_stall low.
REQ-007 cpu_write  input  1  write strobe; held until cpu_stall low.
REQ-008 cpu_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 cpu_rdata  output  32  read data, valid in DONE cycle only.
REQ-010 cpu_stall  output  1  high while an accepted access is incomplete.
REQ-011 cpu_err  output  1  one-cycle pulse in DONE on misalign/timeout/conflict.
REQ-012 bus_req, bus_we  output  1 each  bus request and write qualifier.
REQ-013 bus_addr  output  32  word-aligned address {cpu_addr[31:2],2'b00}.
REQ-014 bus_wdata  output  32  lane-replicated write data.
REQ-015 bus_be  output  4  byte enables.
REQ-016 bus_ready  input  1  target completes request this cycle.
REQ-017 bus_rdata  input  32  read data, valid with bus_ready.

Function
REQ-018 FSM states IDLE, BUSY, DONE; IDLE->BUSY when (cpu_read|cpu_write) and aligned; IDLE->DONE when misaligned; BUSY->DONE on bus_ready or timeout; DONE->IDLE unconditionally.
REQ-019 Address, wdata, we, be latched on IDLE exit; bus outputs driven from latches, stable throughout BUSY.
REQ-020 bus_req high exactly during BUSY; low in IDLE/DONE.
REQ-021 cpu_stall = (state==BUSY) | (state==IDLE & (cpu_read|cpu_write)); low in DONE.
REQ-022 Zero-wait target: strobe in cycle N, bus_req N+1 with ready, cpu_rdata valid and stall low N+2.
REQ-023 bus_be: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?1100:0011; word -> 1111.
REQ-024 bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-025 cpu_rdata: selected lane(s) of bus_rdata zero-extended to 32 bits, captured on BUSY&bus_ready, held only for DONE cycle, 0 otherwise.
REQ-026 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): no bus transaction, DONE with cpu_err=1, cpu_rdata=0.
REQ-027 Timeout counter clears on BUSY entry, increments each BUSY cycle without ready; at count TIMEOUT-1 without ready -> DONE, cpu_err=1, cpu_rdata=0.
REQ-028 bus_ready in IDLE/DONE ignored.
REQ-029 cpu_read and cpu_write both high: write performed, cpu_err=1 in DONE.
REQ-030 Strobe still high in cycle after DONE starts a new access (CPU must drop it).

Reset
REQ-031 reset=0 at rising edge: state IDLE, counter 0, latches 0, next-cycle outputs bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, cpu_err=0.
REQ-032 Reset during BUSY abandons transaction; bus_req low the cycle after reset edge; no DONE, no cpu_err.

Structure
REQ-033 Shared package mem_bus_pkg holds state enum, SIZE_BYTE/HALF/WORD codes, DEFAULT_TIMEOUT.
REQ-034 Combinational sub-module mem_lane_align computes bus_be, bus_wdata, misalign flag, read-lane extraction; FSM, counter, latches in mem_bus_bridge.

Verification
REQ-035 Word read addr 0x100, bus_ready same cycle as bus_req, bus_rdata 0x12345678 -> cpu_rdata 0x12345678 two cycles after strobe, stall low, err 0.
REQ-036 Byte write addr 0x203, wdata 0xAB -> bus_be 1000, bus_wdata 0xABABABAB, bus_addr 0x200, bus_we 1.
REQ-037 Half read addr 0x102, bus_rdata 0xBEEF1234, 3 wait cycles -> cpu_rdata 0x0000BEEF, stall high 5 cycles.
REQ-038 Word read addr 0x101 -> no bus_req, cpu_err pulse, cpu_rdata 0.
REQ-039 TIMEOUT=4, bus_ready stuck 0 -> bus_req high 4 cycles then DONE with cpu_err=1.
REQ-040 Reset asserted mid-BUSY -> bus_req 0 next cycle, state IDLE, no err pulse.
